tt_um_log_fpmul_param: RTL and testbench

Parametrised, byte-serial approximate floating-point multiplier tile for the Tiny Tapeout harness. It multiplies two sign/exponent/mantissa operands using Mitchell logarithmic multiplication, with a selectable shift-add log/antilog correction mode. Operand and result widths are generic. Byte transfers use an explicit valid/ready handshake on the bidirectional pins, so no data value is reserved as a start code.

---
 rtl/log_fpmul_pkg.sv | 34 +++
 rtl/log_fpmul_if.sv | 16 +
 rtl/lfm_corr.sv | 19 +
 rtl/tt_um_log_fpmul_param.sv | 172 +++++++++++++++++
 tb/tb_tt_um_log_fpmul_param.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/log_fpmul_pkg.sv
// Shared types and helpers for the byte-serial Mitchell log multiplier.
// The FSM state enum, the bytes-per-word function, and field-width helpers
// are used by the top level. The BIAS/EMAX/W/NB localparams describe the
// default FP16-style configuration.
package log_fpmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_DECODE, ST_LOG, ST_ADD, ST_ANTILOG, ST_PACK, ST_OUT
  } state_t;

  function automatic int w_of(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int nb_of(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int emax_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int W    = w_of(EXP_W_DEF, MAN_W_DEF);
  localparam int NB   = nb_of(W);
  localparam int BIAS = bias_of(EXP_W_DEF);
  localparam int EMAX = emax_of(EXP_W_DEF);

endpackage

// File: rtl/log_fpmul_if.sv
// Byte-bus bundle for the multiplier tile: the data byte and the
// bidirectional handshake pins (in_valid/mode/out_ready in, busy/out_valid
// out). master = harness side, slave = tile side.
interface log_fpmul_if;
  import log_fpmul_pkg::*;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in,
                  input  uo_out, input uio_out, input uio_oe);
  modport slave  (input  ui_in, input uio_in,
                  output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/lfm_corr.sv
// Shift-add log/antilog correction term c(x) = (t>>3)+(t>>4), where
// t = min(x, ~x). The term is a piecewise-linear approximation of the error
// in log2(1+x) ~= x. The term is largest at mid-scale and is zero at both
// ends.
// Ports: x (mantissa-width fraction), c (correction, same width).
module lfm_corr
  import log_fpmul_pkg::*;
#(
  parameter int MAN_W = 10
) (
  input  logic [MAN_W-1:0] x,
  output logic [MAN_W-1:0] c
);
  logic [MAN_W-1:0] xn, t;

  assign xn = ~x;
  assign t  = (x < xn) ? x : xn;
  assign c  = (t >> 3) + (t >> 4);
endmodule

// File: rtl/tt_um_log_fpmul_param.sv
// Byte-serial approximate FP multiplier (Mitchell log multiplication).
// Ports: clk, rst_n (sync, active low), ena (ignored), ui_in (data byte),
//   uio_in[0] in_valid, [1] mode, [2] out_ready; uo_out (result byte),
//   uio_out[7] busy, [6] out_valid; uio_oe fixed 8'hC0.
// Operands arrive LSB byte first, A then B. The result leaves LSB byte first.
module tt_um_log_fpmul_param
  import log_fpmul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int LW  = w_of(EXP_W, MAN_W);
  localparam int LNB = nb_of(LW);
  localparam int OW  = 8 * LNB;
  localparam int IW  = 2 * OW;
  localparam int EW  = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E    = EW'(bias_of(EXP_W));
  localparam logic [EW-2:0] EMAX_E    = (EW-1)'(emax_of(EXP_W));
  localparam logic [3:0]    LOAD_LAST = 4'(2 * LNB - 1);
  localparam logic [3:0]    OUT_LAST  = 4'(LNB - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic mode_q, mode_d, s_q, s_d, zero_q, zero_d, inf_q, inf_d, ov_q, ov_d;
  logic [IW-1:0] ibuf_q, ibuf_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W-1:0] ma_q, ma_d, mb_q, mb_d, f_q, f_d;
  logic [EW-1:0] e_q, e_d;
  logic [OW-1:0] res_q, res_d;
  logic [7:0] uo_q, uo_d;

  logic in_valid, mode_in, out_ready, busy;
  assign in_valid  = uio_in[0];
  assign mode_in   = uio_in[1];
  assign out_ready = uio_in[2];
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_LOAD);

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:3], ibuf_q};

  logic [LW-1:0] op_a, op_b;
  assign op_a = ibuf_q[LW-1:0];
  assign op_b = ibuf_q[OW+LW-1:OW];

  // ma/mb hold the raw mantissas after DECODE and the log values after LOG.
  // f holds the fraction after ADD and the antilog mantissa after ANTILOG.
  logic [MAN_W-1:0] c_a, c_b, c_f;
  lfm_corr #(.MAN_W(MAN_W)) u_corr_a (.x(ma_q), .c(c_a));
  lfm_corr #(.MAN_W(MAN_W)) u_corr_b (.x(mb_q), .c(c_b));
  lfm_corr #(.MAN_W(MAN_W)) u_corr_f (.x(f_q),  .c(c_f));

  logic [MAN_W:0] sum;
  assign sum = {1'b0, ma_q} + {1'b0, mb_q};

  logic [OW-1:0] res_shift;
  assign res_shift = res_q >> 8;

  // e_q is a two's-complement value. The top bit set means the exponent is negative.
  logic e_ovf, e_unf;
  assign e_unf = e_q[EW-1] || (e_q == '0);
  assign e_ovf = !e_q[EW-1] && (e_q[EW-2:0] >= EMAX_E);

  // Special operands take precedence over exponent range checks.
  logic [OW-1:0] pack_w;
  always_comb begin
    pack_w = '0;
    pack_w[LW-1] = s_q;
    if (inf_q || (!zero_q && e_ovf)) begin
      pack_w[LW-2:MAN_W] = '1;
    end else if (!zero_q && !e_unf) begin
      pack_w[LW-2:MAN_W] = e_q[EXP_W-1:0];
      pack_w[MAN_W-1:0]  = f_q;
    end
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; mode_d = mode_q; ibuf_d = ibuf_q;
    s_d = s_q; zero_d = zero_q; inf_d = inf_q; ea_d = ea_q; eb_d = eb_q;
    ma_d = ma_q; mb_d = mb_q; f_d = f_q; e_d = e_q; res_d = res_q;
    uo_d = uo_q; ov_d = ov_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        ibuf_d  = {ui_in, ibuf_q[IW-1:8]};
        mode_d  = mode_in;
        cnt_d   = 4'd1;
        state_d = ST_LOAD;
      end
      ST_LOAD: if (in_valid) begin
        ibuf_d = {ui_in, ibuf_q[IW-1:8]};
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DECODE: begin
        s_d    = op_a[LW-1] ^ op_b[LW-1];
        ea_d   = op_a[LW-2:MAN_W];
        eb_d   = op_b[LW-2:MAN_W];
        ma_d   = op_a[MAN_W-1:0];
        mb_d   = op_b[MAN_W-1:0];
        zero_d = (op_a[LW-2:MAN_W] == '0) || (op_b[LW-2:MAN_W] == '0);
        inf_d  = (&op_a[LW-2:MAN_W]) || (&op_b[LW-2:MAN_W]);
        state_d = ST_LOG;
      end
      ST_LOG: begin
        if (mode_q) begin
          ma_d = ma_q + c_a;
          mb_d = mb_q + c_b;
        end
        state_d = ST_ADD;
      end
      ST_ADD: begin
        f_d = sum[MAN_W-1:0];
        e_d = {2'b00, ea_q} + {2'b00, eb_q} + {{(EW-1){1'b0}}, sum[MAN_W]} - BIAS_E;
        state_d = ST_ANTILOG;
      end
      ST_ANTILOG: begin
        if (mode_q) f_d = f_q - c_f;
        state_d = ST_PACK;
      end
      ST_PACK: begin
        res_d   = pack_w;
        uo_d    = pack_w[7:0];
        ov_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: if (out_ready) begin
        if (cnt_q == OUT_LAST) begin
          ov_d    = 1'b0;
          uo_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          res_d = res_shift;
          uo_d  = res_shift[7:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; cnt_q <= '0; mode_q <= 1'b0; ibuf_q <= '0;
      s_q <= 1'b0; zero_q <= 1'b0; inf_q <= 1'b0; ea_q <= '0; eb_q <= '0;
      ma_q <= '0; mb_q <= '0; f_q <= '0; e_q <= '0; res_q <= '0;
      uo_q <= '0; ov_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; mode_q <= mode_d; ibuf_q <= ibuf_d;
      s_q <= s_d; zero_q <= zero_d; inf_q <= inf_d; ea_q <= ea_d; eb_q <= eb_d;
      ma_q <= ma_d; mb_q <= mb_d; f_q <= f_d; e_q <= e_d; res_q <= res_d;
      uo_q <= uo_d; ov_q <= ov_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {busy, ov_q, 6'b0};
  assign uio_oe  = 8'b1100_0000;
endmodule

// File: tb/tb_tt_um_log_fpmul_param.sv
// Directed bench: an FP16 instance (EXP_W=5, MAN_W=10) and an 8-bit instance
// (EXP_W=4, MAN_W=3). Expected results are hand-derived Mitchell products.
module tb_tt_um_log_fpmul_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [7:0] din, din4;
  logic ival, ival4, mode_b, ordy, ordy4;
  int n_chk = 0;
  int n_fail = 0;

  log_fpmul_if bus ();
  log_fpmul_if bus4 ();
  assign bus.ui_in   = din;
  assign bus.uio_in  = {5'b0, ordy, mode_b, ival};
  assign bus4.ui_in  = din4;
  assign bus4.uio_in = {5'b0, ordy4, mode_b, ival4};

  tt_um_log_fpmul_param dut (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(bus.ui_in), .uio_in(bus.uio_in),
    .uo_out(bus.uo_out), .uio_out(bus.uio_out), .uio_oe(bus.uio_oe));

  tt_um_log_fpmul_param #(.EXP_W(4), .MAN_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(bus4.ui_in), .uio_in(bus4.uio_in),
    .uo_out(bus4.uo_out), .uio_out(bus4.uio_out), .uio_oe(bus4.uio_oe));

  logic ov, busy, ov4, busy4;
  assign ov    = bus.uio_out[6];
  assign busy  = bus.uio_out[7];
  assign ov4   = bus4.uio_out[6];
  assign busy4 = bus4.uio_out[7];

  // Stimulus drivers. Each starts and ends on a falling edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m, input int gap);
    logic [31:0] w;
    w = {b, a};
    mode_b = m;
    for (int i = 0; i < 4; i++) begin
      din = w[8*i +: 8];
      ival = 1'b1;
      @(negedge clk);
      if (gap > 0 && i < 3) begin
        ival = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    ival = 1'b0;
  endtask

  task automatic recv(output logic [15:0] w, output bit ok);
    int t;
    ok = 1'b1;
    w = '0;
    ordy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!ov && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!ov) ok = 1'b0;
      w[8*i +: 8] = bus.uo_out;
      @(negedge clk);
    end
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; din4 = '0; ival = 1'b0; ival4 = 1'b0;
    mode_b = 1'b0; ordy = 1'b0; ordy4 = 1'b0;
    @(negedge clk); @(negedge clk);
    n_chk++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo: got %h expected 00", bus.uo_out); end
    n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio: got %h expected 00", bus.uio_out); end
    n_chk++; if (bus.uio_oe !== 8'hC0) begin n_fail++; $display("FAIL reset_oe: got %h expected c0", bus.uio_oe); end
    n_chk++; if (bus4.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo4: got %h expected 00", bus4.uo_out); end
    n_chk++; if (bus4.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio4: got %h expected 00", bus4.uio_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    send(16'h4200, 16'h4200, 1'b0, 0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid got %b expected 0", ov); end
    @(negedge clk);
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b expected 1", ov); end
    n_chk++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL lat_byte0: got %h expected 00", bus.uo_out); end
    ordy = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.uo_out !== 8'h48 || ov !== 1'b1) begin n_fail++; $display("FAIL lat_byte1: got %h/%b expected 48/1", bus.uo_out, ov); end
    @(negedge clk);
    n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL lat_done: uio_out got %h expected 00", bus.uio_out); end
    ordy = 1'b0;
  endtask

  task automatic test_vectors();
    logic [15:0] va [9] = '{16'h4200, 16'h4200, 16'hC000, 16'h0000, 16'h8000, 16'h7800, 16'h0400, 16'h7C00, 16'h3C00};
    logic [15:0] vb [9] = '{16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h4200, 16'h7800, 16'h0400, 16'h0000, 16'h4500};
    logic        vm [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] ve [9] = '{16'h4800, 16'h489A, 16'hC600, 16'h0000, 16'h8000, 16'h7C00, 16'h0000, 16'h7C00, 16'h4500};
    logic [15:0] w;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      send(va[i], vb[i], vm[i], 0);
      recv(w, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL vec%0d_timeout: out_valid never seen, expected within 40 cycles", i); end
      n_chk++; if (w !== ve[i]) begin n_fail++; $display("FAIL vec%0d: got %h expected %h", i, w, ve[i]); end
    end
  endtask

  task automatic test_handshake();
    logic [15:0] w;
    bit ok;
    int t;
    send(16'h4200, 16'h4200, 1'b1, 2);
    t = 0;
    while (!ov && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL hs_valid: got %b expected 1", ov); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (bus.uo_out !== 8'h9A || ov !== 1'b1) begin n_fail++; $display("FAIL hs_stall%0d: got %h/%b expected 9a/1", i, bus.uo_out, ov); end
    end
    recv(w, ok);
    n_chk++; if (!ok || w !== 16'h489A) begin n_fail++; $display("FAIL hs_result: got %h ok=%b expected 489a", w, ok); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    bit ok;
    send(16'h4200, 16'h4200, 1'b0, 0);
    recv(w, ok);
    n_chk++; if (!ok || w !== 16'h4800) begin n_fail++; $display("FAIL b2b_first: got %h ok=%b expected 4800", w, ok); end
    send(16'hC000, 16'h4200, 1'b0, 0);
    recv(w, ok);
    n_chk++; if (!ok || w !== 16'hC600) begin n_fail++; $display("FAIL b2b_second: got %h ok=%b expected c600", w, ok); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    bit ok;
    logic [31:0] pw;
    pw = {16'h4200, 16'h4200};
    mode_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = pw[8*i +: 8];
      ival = 1'b1;
      @(negedge clk);
    end
    ival = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL rst_load: got %h/%h expected 00/00", bus.uo_out, bus.uio_out); end
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h4200, 16'h4200, 1'b1, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL rst_out: got %h/%h expected 00/00", bus.uo_out, bus.uio_out); end
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hC000, 16'h4200, 1'b1, 0);
    recv(w, ok);
    n_chk++; if (!ok || w !== 16'hC610) begin n_fail++; $display("FAIL rst_after: got %h ok=%b expected c610", w, ok); end
  endtask

  task automatic test_variant();
    mode_b = 1'b0;
    din4 = 8'h40; ival4 = 1'b1;
    @(negedge clk);
    din4 = 8'h44;
    @(negedge clk);
    ival4 = 1'b0;
    n_chk++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL v4_busy: got %b expected 1", busy4); end
    repeat (4) @(negedge clk);
    n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL v4_early: got %b expected 0", ov4); end
    @(negedge clk);
    n_chk++; if (ov4 !== 1'b1 || bus4.uo_out !== 8'h4C) begin n_fail++; $display("FAIL v4_result: got %h/%b expected 4c/1", bus4.uo_out, ov4); end
    ordy4 = 1'b1;
    @(negedge clk);
    n_chk++; if (bus4.uio_out !== 8'h00) begin n_fail++; $display("FAIL v4_done: uio_out got %h expected 00", bus4.uio_out); end
    ordy4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
